dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the ARM core's data port.
- Accepts word-wide load and store requests from the core, i.e. the DataAdr, WriteData and MemWrite side of top.
- Inserts a configurable number of wait states, then returns ReadData with a single-cycle ready pulse.
- Flags misaligned and out-of-range accesses.
- Replaces the zero-latency memory, so the multicycle core and the benches can exercise stalls.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words. Must be a power of 2, at least 4.
- WAIT_STATES, 2: extra cycles between request acceptance and the ready pulse. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  1  access request. Held high, with stable fields, until ready is seen.
- MemWrite  input  1  1 = store, 0 = load. Sampled at acceptance.
- DataAdr  input  32  byte address. Sampled at acceptance.
- WriteData  input  32  store data. Sampled at acceptance.
- ByteEn  input  4  byte lane enables for stores. Bit i covers WriteData[8i+7:8i]. Ignored for loads.
- ReadData  output  32  load data. Valid only while ready=1 and MemWrite was 0.
- ready  output  1  one-cycle completion pulse.
- err  output  1  qualifies ready. 1 = access rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; wait counter cleared.
  - ready=0, err=0, ReadData=0.
  - Memory array contents are NOT cleared.
- Reset mid-operation aborts any access. A pending store never commits.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1, latch MemWrite, DataAdr, WriteData and ByteEn, and load the counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise go to RESP.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP next cycle.
- RESP:
  - ready=1 for exactly this one cycle.
  - Perform the store or read the memory in this cycle, using the latched fields.
  - Return to IDLE.
- Latency: req sampled high at edge N gives ready high during the cycle after edge N+1+WAIT_STATES.
- Re-acceptance:
  - Ready and acceptance of a new request are never in the same cycle.
  - In IDLE the next cycle, req is sampled again.
  - So back-to-back requests are spaced WAIT_STATES+2 cycles apart.
- Word index is DataAdr[log2(DEPTH_WORDS)+1:2].
- Error conditions: DataAdr[1:0]!=0, or DataAdr >= 4*DEPTH_WORDS. On an error:
  - err=1 together with ready.
  - No memory write.
  - ReadData=0.
- Stores:
  - Only lanes with ByteEn=1 are modified.
  - ByteEn=0000 is a legal no-op that still completes with ready.
  - ReadData=0 during a store response.
- Outputs ReadData and err are registered. Their values hold at 0 outside the ready cycle.
- Changes on req or the data fields after acceptance are ignored until the FSM returns to IDLE.

Optional Feature:
- Macro: DMEM_WRITE_LOG_EN.
- When defined, three extra output ports are added:
  - log_valid (1 bit): one-cycle pulse on every successful, non-error store.
  - log_addr (32 bits): byte address of that store.
  - log_data (32 bits): merged word after the byte-lane update.
- All three reset to 0. log_addr and log_data hold their values until the next logged store.
- Benches use these to check stores without probing the core, e.g. expected address 100, data 7.
- When not defined, these ports and their registers do not exist, and the behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - the state typedef, dmem_state_t {IDLE, WAIT, RESP};
  - the constants WORD_BYTES=4 and MAX_WAIT_STATES=15;
  - the function byte_merge(old, new, be).
- One sub-module: dmem_array, a synchronous single-port RAM with lane write enables.
- The FSM, counter and error logic stay in dmem_responder.

Test Plan:
- Store then load, WAIT_STATES=2:
  - Store DataAdr=100, WriteData=7, ByteEn=1111 -> ready at cycle 4 after acceptance, err=0.
  - Then load 100 -> ReadData=7.
- Byte lanes:
  - Store 0x11223344 to address 96, then store 0xAABBCCDD with ByteEn=0101.
  - Load 96 -> 0x11BB33DD.
- Errors:
  - Load at address 102 -> ready, err=1, ReadData=0.
  - Store at address 256 with DEPTH_WORDS=64 -> err=1; the memory word at index 0 is unchanged.
- Zero wait, WAIT_STATES=0, with req held high for two back-to-back loads -> ready pulses exactly 2 cycles apart.
- Reset mid-access: assert reset during WAIT of a store of 0xDEADBEEF to address 8 -> ready never pulses, and a subsequent load of 8 returns the old value.
- With DMEM_WRITE_LOG_EN: store 7 to address 100 -> log_valid pulses once with log_addr=100 and log_data=7. An errored store produces no pulse.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   dmem_state_t     : responder FSM states (IDLE, WAIT, RESP)
//   WORD_BYTES       : bytes per memory word
//   MAX_WAIT_STATES  : largest wait-state count the 4-bit counter holds
//   byte_merge()     : lane-wise merge of a store into an existing word
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_WAIT_STATES = 15;

  // Bit i of be selects new_w[8i+7:8i]; other lanes keep old_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word RAM with byte-lane write enables.
//   clk     : rising-edge clock
//   i_en    : port enable (read or write this cycle)
//   i_we    : 1 = write the lanes selected by i_be
//   i_idx   : word index
//   i_wdata : store data
//   i_be    : byte lane enables
//   o_q     : registered port output; on a write it carries the merged word
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_q
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;
  logic [31:0] w_merged;

  assign w_merged = byte_merge(r_mem[i_idx], i_wdata, i_be);

  // Write-first on stores so the write log can see the updated word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_idx] <= w_merged;
        r_q          <= w_merged;
      end else begin
        r_q          <= r_mem[i_idx];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data-memory responder with programmable wait
// states, single-cycle ready pulse and error flag for misaligned or
// out-of-range accesses.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   req       : access request, held until ready
//   MemWrite  : 1 = store, 0 = load (sampled at acceptance)
//   DataAdr   : byte address (sampled at acceptance)
//   WriteData : store data (sampled at acceptance)
//   ByteEn    : store byte lane enables (sampled at acceptance)
//   ReadData  : load data, non-zero only in a successful load's ready cycle
//   ready     : one-cycle completion pulse
//   err       : qualifies ready, 1 = access rejected
// Optional build macro DMEM_WRITE_LOG_EN adds log_valid/log_addr/log_data,
// a record of every successful store and the merged word it produced.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        err
`ifdef DMEM_WRITE_LOG_EN
  ,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_L =
    4'((WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES);
  localparam logic [32:0] ADDR_LIMIT = 33'(WORD_BYTES * DEPTH_WORDS);

  dmem_state_t r_state, w_next;
  logic [3:0]  r_cnt;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  logic        w_accept;
  logic        w_resp;
  logic        w_bad;
  logic        w_mem_en;
  logic        w_mem_we;
  logic [31:0] w_q;

  logic        r_ready;
  logic        r_err;
  logic        r_rd_ok;

  assign w_accept = (r_state == IDLE) && req;
  assign w_resp   = (r_state == RESP);
  assign w_bad    = (r_addr[1:0] != 2'b00) || ({1'b0, r_addr} >= ADDR_LIMIT);
  assign w_mem_en = w_resp && !w_bad;
  assign w_mem_we = w_mem_en && r_we;

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req) w_next = (WS_L == 4'd0) ? RESP : WAIT;
      WAIT: if (r_cnt <= 4'd1) w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---- wait-state counter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_cnt <= 4'd0;
    else if (w_accept)         r_cnt <= WS_L;
    else if (r_state == WAIT)  r_cnt <= r_cnt - 4'd1;
  end

  // ---- request capture (data only, not reset) ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= MemWrite;
      r_addr  <= DataAdr;
      r_wdata <= WriteData;
      r_be    <= ByteEn;
    end
  end

  // ---- memory access in RESP ----
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .i_en   (w_mem_en),
    .i_we   (w_mem_we),
    .i_idx  (r_addr[AW+1:2]),
    .i_wdata(r_wdata),
    .i_be   (r_be),
    .o_q    (w_q)
  );

  // ---- response registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_ready <= w_resp;
      r_err   <= w_resp && w_bad;
      r_rd_ok <= w_resp && !w_bad && !r_we;
    end
  end

  // The RAM output register is the data register; r_rd_ok forces zero
  // outside a successful load response.
  assign ReadData = r_rd_ok ? w_q : 32'd0;
  assign ready    = r_ready;
  assign err      = r_err;

`ifdef DMEM_WRITE_LOG_EN
  logic        r_log_valid;
  logic [31:0] r_log_addr;
  logic [31:0] r_log_data;

  // During the pulse the merged word comes straight from the RAM output
  // register; it is copied into r_log_data so it holds afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_log_valid <= 1'b0;
      r_log_addr  <= 32'd0;
      r_log_data  <= 32'd0;
    end else begin
      r_log_valid <= w_mem_we;
      if (w_mem_we)    r_log_addr <= r_addr;
      if (r_log_valid) r_log_data <= w_q;
    end
  end

  assign log_valid = r_log_valid;
  assign log_addr  = r_log_addr;
  assign log_data  = r_log_valid ? w_q : r_log_data;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, WAIT_STATES = 2
  logic        reset, req, MemWrite;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic [3:0]  ByteEn;
  logic        ready, err;
`ifdef DMEM_WRITE_LOG_EN
  logic        log_valid;
  logic [31:0] log_addr, log_data;
`endif

  // second instance, WAIT_STATES = 0
  logic        reset0, req0, we0;
  logic [31:0] adr0, wd0, rd0;
  logic [3:0]  be0;
  logic        ready0, err0;
`ifdef DMEM_WRITE_LOG_EN
  logic        log_valid0;
  logic [31:0] log_addr0, log_data0;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .req(req), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .ByteEn(ByteEn),
    .ReadData(ReadData), .ready(ready), .err(err)
`ifdef DMEM_WRITE_LOG_EN
    , .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset0), .req(req0), .MemWrite(we0),
    .DataAdr(adr0), .WriteData(wd0), .ByteEn(be0),
    .ReadData(rd0), .ready(ready0), .err(err0)
`ifdef DMEM_WRITE_LOG_EN
    , .log_valid(log_valid0), .log_addr(log_addr0), .log_data(log_data0)
`endif
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        is_st;
    logic [31:0] addr;
    logic [31:0] word;
    int          rcyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_la = 32'd0, last_ld = 32'd0;
  int          cyc = 0;
  int          vectors = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: word memory plus the address/lane rules.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int gap);
    exp_t e;
    bit   seen;
    int   w;
    e.err   = (a % 4 != 0) || (a >= 4 * DEPTH);
    e.is_st = we;
    e.addr  = a;
    e.rdata = 32'd0;
    e.word  = 32'd0;
    if (!e.err) begin
      w = int'(a / 4);
      if (we) begin
        e.word = mdl[w];
        for (int i = 0; i < 4; i++)
          if (be[i]) e.word[8*i +: 8] = d[8*i +: 8];
        mdl[w] = e.word;
      end else begin
        e.rdata = mdl[w];
      end
    end
    e.rcyc = cyc + 2 + WS;
    sbq.push_back(e);
    req = 1'b1; MemWrite = we; DataAdr = a; WriteData = d; ByteEn = be;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) begin seen = 1'b1; break; end
      // fields are ignored once accepted
      MemWrite = $urandom_range(0, 1); DataAdr = $urandom; WriteData = $urandom;
      ByteEn = 4'($urandom);
    end
    req = 1'b0;
    if (!seen) begin
      vectors++; fails++;
      $display("FAIL ready timeout: got no ready, want ready for addr %h", a);
      sbq.delete();
    end
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: compares every response of the main instance.
  always @(negedge clk) begin
    if (!reset) begin
      last_la = 32'd0;
      last_ld = 32'd0;
    end else if (ready) begin
      if (sbq.size() == 0) begin
        vectors++; fails++;
        $display("FAIL unexpected ready: got ready=1, want 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("err", 32'(err), 32'(mon_e.err));
        check("rdata", ReadData, mon_e.rdata);
        check("latency", cyc, mon_e.rcyc);
`ifdef DMEM_WRITE_LOG_EN
        check("log_valid", 32'(log_valid), 32'(mon_e.is_st && !mon_e.err));
        if (mon_e.is_st && !mon_e.err) begin
          check("log_addr", log_addr, mon_e.addr);
          check("log_data", log_data, mon_e.word);
          last_la = mon_e.addr;
          last_ld = mon_e.word;
        end
`endif
      end
    end else begin
      if (err !== 1'b0 || ReadData !== 32'd0) begin
        fails++;
        $display("FAIL idle outputs: got err=%b rdata=%h, want 0/0", err, ReadData);
      end
`ifdef DMEM_WRITE_LOG_EN
      if (log_valid !== 1'b0 || log_addr !== last_la || log_data !== last_ld) begin
        fails++;
        $display("FAIL log hold: got %b %h %h, want 0 %h %h",
                 log_valid, log_addr, log_data, last_la, last_ld);
      end
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, t0, sel;
    int          rc [2];
    logic [31:0] rdv [2];
    logic        erv [2];
    logic [31:0] a;
    bit          seen;

    reset = 1'b0; req = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; ByteEn = '0;
    reset0 = 1'b0; req0 = 1'b0; we0 = 1'b0; adr0 = '0; wd0 = '0; be0 = '0;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(ready), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset rdata", ReadData, 32'd0);
    check("reset ready0", 32'(ready0), 32'd0);
    reset = 1'b1; reset0 = 1'b1;
    @(negedge clk);

    // fill memory so every later load has a known expectation
    for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF, $urandom_range(0, 1));

    // store then load
    access(1'b1, 32'd100, 32'd7, 4'hF, 0);
    access(1'b0, 32'd100, 32'd0, 4'h0, 1);
    // byte lanes
    access(1'b1, 32'd96, 32'h11223344, 4'hF, 0);
    access(1'b1, 32'd96, 32'hAABBCCDD, 4'b0101, 0);
    access(1'b0, 32'd96, 32'd0, 4'h0, 0);
    // errors
    access(1'b0, 32'd102, 32'd0, 4'h0, 0);
    access(1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, 0);
    access(1'b0, 32'd0, 32'd0, 4'h0, 0);
    // ByteEn=0000 no-op store
    access(1'b1, 32'd40, 32'hCAFEF00D, 4'h0, 0);
    access(1'b0, 32'd40, 32'd0, 4'h0, 2);

    // reset while a store waits: it must never complete
    req = 1'b1; MemWrite = 1'b1; DataAdr = 32'd8; WriteData = 32'hDEADBEEF; ByteEn = 4'hF;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-reset ready", 32'(ready), 32'd0);
    check("mid-reset rdata", ReadData, 32'd0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    access(1'b0, 32'd8, 32'd0, 4'h0, 0);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(4 * DEPTH, 4095));
      else               a = $urandom;
      access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    // zero wait states: store, then two back-to-back loads with req held
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'd4; wd0 = 32'h13579BDF; be0 = 4'hF;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready0) begin seen = 1'b1; break; end
    end
    req0 = 1'b0;
    check("ws0 store ready", 32'(seen), 32'd1);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; adr0 = 32'd4;
    t0 = cyc + 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready0) begin
        rc[n] = cyc; rdv[n] = rd0; erv[n] = err0;
        n++;
        if (n == 2) begin req0 = 1'b0; break; end
      end
    end
    check("ws0 pulses", 32'(n), 32'd2);
    if (n == 2) begin
      check("ws0 first latency", 32'(rc[0] - t0), 32'd1);
      check("ws0 spacing", 32'(rc[1] - rc[0]), 32'd2);
      check("ws0 rdata0", rdv[0], 32'h13579BDF);
      check("ws0 rdata1", rdv[1], 32'h13579BDF);
      check("ws0 err", 32'({erv[1], erv[0]}), 32'd0);
    end
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready0) n++;
    end
    check("ws0 no extra pulse", 32'(n), 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
